// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants for the inter-stage pipeline registers (ID/EX, EX/MEM, MEM/WB).
package pipe_stage_reg_pkg;

   // Default boundary widths: RB 32 + ALU_OUT 32 + RD 5 + pad
   localparam int PIPE_DATA_W = 74;
   localparam int PIPE_CTRL_W = 6;

   // Control field layout: RAM_CTRL[3:0], L, RF_LE
   localparam int CTRL_RAM_LSB = 0;
   localparam int CTRL_RAM_W   = 4;
   localparam int CTRL_L_BIT   = 4;
   localparam int CTRL_RFLE_BIT = 5;

   // Bubble pattern: no RAM op, no load, no register-file write
   localparam logic [PIPE_CTRL_W-1:0] PIPE_CTRL_NOP = '0;

   localparam int OCC_W = 2;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready bus carrying separate data and control payloads between stages.
interface pipe_stage_reg_if
   import pipe_stage_reg_pkg::*;
#(
   parameter int DATA_W = PIPE_DATA_W,
   parameter int CTRL_W = PIPE_CTRL_W
);
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;
   logic [CTRL_W-1:0] ctrl;

   modport master (output valid, output data, output ctrl, input ready);
   modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline register with valid/ready flow control, flush-to-bubble and optional skid slot.
// The main slot drives the output; the skid slot catches one entry accepted while the
// main slot is stalled, so in_ready can come straight from a flop.
module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int                DATA_W   = PIPE_DATA_W,
   parameter int                CTRL_W   = PIPE_CTRL_W,
   parameter logic [CTRL_W-1:0] CTRL_NOP = CTRL_W'(PIPE_CTRL_NOP),
   parameter bit                SKID     = 1'b1
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic             flush,
   pipe_stage_reg_if.slave  up,
   pipe_stage_reg_if.master dn,
   output logic [OCC_W-1:0] occupancy
);

   logic              main_valid_q, main_valid_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic              skid_valid_q, skid_valid_d;
   logic [DATA_W-1:0] skid_data_q;
   logic [CTRL_W-1:0] skid_ctrl_q;
   logic [OCC_W-1:0]  occupancy_q, occupancy_d;

   logic in_ready;
   logic accept;
   logic load_main;

   // Handshake terms; main slot may reload whenever it is empty or being emitted
   always_comb begin
      load_main = !main_valid_q || dn.ready;
      in_ready  = SKID ? !skid_valid_q : load_main;
      accept    = up.valid && in_ready;
   end

   // Main slot next state: skid entry has priority over the input to keep FIFO order
   always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      main_ctrl_d  = main_ctrl_q;
      if (flush) begin
         main_valid_d = 1'b0;
      end else if (load_main) begin
         if (skid_valid_q) begin
            main_valid_d = 1'b1;
            main_data_d  = skid_data_q;
            main_ctrl_d  = skid_ctrl_q;
         end else begin
            main_valid_d = accept;
            if (accept) begin
               main_data_d = up.data;
               main_ctrl_d = up.ctrl;
            end
         end
      end
      occupancy_d = OCC_W'(main_valid_d) + OCC_W'(skid_valid_d);
   end

   generate
      if (SKID) begin : g_skid
         logic [DATA_W-1:0] skid_data_d;
         logic [CTRL_W-1:0] skid_ctrl_d;

         // Skid fills only when an accept lands on a stalled main slot; drains into main
         always_comb begin
            skid_valid_d = skid_valid_q;
            skid_data_d  = skid_data_q;
            skid_ctrl_d  = skid_ctrl_q;
            if (flush) begin
               skid_valid_d = 1'b0;
            end else if (load_main && skid_valid_q) begin
               skid_valid_d = accept;
               if (accept) begin
                  skid_data_d = up.data;
                  skid_ctrl_d = up.ctrl;
               end
            end else if (!load_main && accept) begin
               skid_valid_d = 1'b1;
               skid_data_d  = up.data;
               skid_ctrl_d  = up.ctrl;
            end
         end

         // Skid slot registers
         always_ff @(posedge clk) begin
            if (Reset) begin
               skid_valid_q <= 1'b0;
               skid_data_q  <= '0;
               skid_ctrl_q  <= CTRL_NOP;
            end else begin
               skid_valid_q <= skid_valid_d;
               skid_data_q  <= skid_data_d;
               skid_ctrl_q  <= skid_ctrl_d;
            end
         end
      end else begin : g_noskid
         assign skid_valid_d = 1'b0;
         assign skid_valid_q = 1'b0;
         assign skid_data_q  = '0;
         assign skid_ctrl_q  = CTRL_NOP;
      end
   endgenerate

   // Main slot and occupancy registers
   always_ff @(posedge clk) begin
      if (Reset) begin
         main_valid_q <= 1'b0;
         main_data_q  <= '0;
         main_ctrl_q  <= CTRL_NOP;
         occupancy_q  <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         main_data_q  <= main_data_d;
         main_ctrl_q  <= main_ctrl_d;
         occupancy_q  <= occupancy_d;
      end
   end

   // Outputs; control is forced to the NOP pattern whenever the slot is a bubble
   always_comb begin
      up.ready  = in_ready;
      dn.valid  = main_valid_q;
      dn.data   = main_data_q;
      dn.ctrl   = main_valid_q ? main_ctrl_q : CTRL_NOP;
      occupancy = occupancy_q;
   end

endmodule
